// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing the single framebuffer write port between drawing units.
// Holds each grant until the owner finishes, forwards its pixels and guards it with a no-pixel watchdog.
module plot_arbiter #(
    parameter int         NREQ      = 4,
    parameter int         XMAX      = 160,
    parameter int         YMAX      = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         TIMEOUT   = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   done,
    input  logic [NREQ-1:0]   pix_valid,
    input  logic [8*NREQ-1:0] x_in,
    input  logic [7*NREQ-1:0] y_in,
    input  logic [3*NREQ-1:0] colour_in,
    input  logic              erase,
    output logic [NREQ-1:0]   grant,
    output logic              plot,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              busy,
    output logic [14:0]       pix_count,
    output logic              timeout_err
);
    localparam int         PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         WW   = $clog2(TIMEOUT + 1);
    localparam logic [8:0] XLIM = 9'(XMAX);
    localparam logic [7:0] YLIM = 8'(YMAX);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rr, owner, sel;
    logic            found;
    logic [WW-1:0]   watchdog;
    logic [7:0]      own_x;
    logic [6:0]      own_y;
    logic [2:0]      own_c;
    logic            own_pv, own_done, own_req, in_range, wd_expired, release_g;

    // First requester at or after the rr pointer, wrapping at NREQ.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(rr) + i) % NREQ]) begin
                found = 1'b1;
                sel   = PW'((int'(rr) + i) % NREQ);
            end
        end
    end

    assign own_x      = x_in[8*owner +: 8];
    assign own_y      = y_in[7*owner +: 7];
    assign own_c      = colour_in[3*owner +: 3];
    assign own_pv     = pix_valid[owner];
    assign own_done   = done[owner];
    assign own_req    = req[owner];
    assign in_range   = ({1'b0, own_x} < XLIM) && ({1'b0, own_y} < YLIM);
    assign wd_expired = (watchdog == WW'(TIMEOUT));
    assign release_g  = own_done || !own_req || wd_expired;
    assign busy       = (state == GRANT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = GRANT;
            GRANT:   if (release_g) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            owner       <= '0;
            rr          <= '0;
            plot        <= 1'b0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            pix_count   <= '0;
            watchdog    <= '0;
            timeout_err <= 1'b0;
        end else begin
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= '0;
                        grant[sel] <= 1'b1;
                        owner      <= sel;
                        pix_count  <= '0;
                        watchdog   <= '0;
                    end
                end
                GRANT: begin
                    // Pixel is forwarded even in the release cycle.
                    if (own_pv) begin
                        watchdog <= '0;
                        if (in_range) begin
                            plot   <= 1'b1;
                            x      <= own_x;
                            y      <= own_y;
                            colour <= erase ? BG_COLOUR : own_c;
                            if (pix_count != 15'h7fff) pix_count <= pix_count + 15'd1;
                        end
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                    if (release_g) begin
                        grant <= '0;
                        if (owner == PW'(NREQ - 1)) rr <= '0;
                        else                        rr <= owner + 1'b1;
                        if (wd_expired) timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: expected pixels queued at drive time, popped on plot.
module tb_plot_arbiter;
    localparam int NREQ = 4;

    logic              clock, reset;
    logic [NREQ-1:0]   req, done, pix_valid;
    logic [8*NREQ-1:0] x_in;
    logic [7*NREQ-1:0] y_in;
    logic [3*NREQ-1:0] colour_in;
    logic              erase;
    logic [NREQ-1:0]   grant;
    logic              plot, busy, timeout_err;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic [14:0]       pix_count;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         cyc;
    } pix_t;

    pix_t sbq[$];
    int   n_chk = 0, n_err = 0, n_push = 0, n_plot = 0, cyc = 0;

    plot_arbiter #(.NREQ(NREQ), .XMAX(160), .YMAX(120), .BG_COLOUR(3'b000), .TIMEOUT(1023)) dut (
        .clock(clock), .reset(reset), .req(req), .done(done), .pix_valid(pix_valid),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .erase(erase),
        .grant(grant), .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy),
        .pix_count(pix_count), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every plot must match the oldest queued pixel, one cycle after it was driven.
    initial forever begin
        pix_t e;
        @(negedge clock);
        if (plot === 1'b1) begin
            n_plot++;
            if (sbq.size() == 0) chk("spurious_plot", 32'(sbq.size()), 32'd1);
            else begin
                e = sbq.pop_front();
                chk("pix", 32'({x, y, colour}), 32'({e.x, e.y, e.c}));
                chk("pix_lat", 32'(cyc), 32'(e.cyc + 1));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_pix(input int u, input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
        x_in[8*u +: 8]      = xv;
        y_in[7*u +: 7]      = yv;
        colour_in[3*u +: 3] = cv;
    endtask

    // Drive one pixel from unit u for a cycle; queue it when a plot is expected.
    task automatic send(input int u, input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv,
                        input logic ers, input logic expect_plot);
        pix_t e;
        set_pix(u, xv, yv, cv);
        erase        = ers;
        pix_valid[u] = 1'b1;
        if (expect_plot) begin
            e.x = xv; e.y = yv; e.c = ers ? 3'b000 : cv; e.cyc = cyc;
            sbq.push_back(e);
            n_push++;
        end
        tick();
        pix_valid[u] = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp);
        int n;
        n = 0;
        while (grant == '0 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(grant), 32'(exp));
    endtask

    task automatic release_unit(input int u);
        done[u] = 1'b1;
        req     = '0;
        tick();
        done = '0;
    endtask

    initial begin
        int          n;
        int          u;
        logic [NREQ-1:0] e;
        reset = 1'b1; req = '0; done = '0; pix_valid = '0;
        x_in = '0; y_in = '0; colour_in = '0; erase = 1'b0;
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xyc", 32'({x, y, colour}), 32'd0);
        chk("rst_cnt", 32'(pix_count), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();

        // Round robin across all four units, 3 pixels each.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            u = k % NREQ;
            e = 4'b0001 << u;
            wait_grant("rr_grant", e);
            chk("rr_busy", 32'(busy), 32'd1);
            for (int j = 0; j < 3; j++)
                send(u, 8'(u * 20 + j), 7'(j + 1), 3'(u + j), 1'b0, 1'b1);
            done[u] = 1'b1;
            if (k == 4) req = '0;
            tick();
            done = '0;
            chk("rr_count", 32'(pix_count), 32'd3);
            if (k < 4) begin
                n = 0;
                while (grant == '0 && n < 10) begin
                    n++;
                    tick();
                end
                chk("rr_gap", 32'(n), 32'd2);
            end
        end

        // Owner 1: normal colour then erase colour.
        req = 4'b0010;
        wait_grant("erase_grant", 4'b0010);
        send(1, 8'd10, 7'd20, 3'b101, 1'b0, 1'b1);
        chk("colour_norm", 32'({plot, colour}), 32'({1'b1, 3'b101}));
        send(1, 8'd10, 7'd20, 3'b101, 1'b1, 1'b1);
        chk("colour_erase", 32'({plot, colour}), 32'({1'b1, 3'b000}));
        erase = 1'b0;
        release_unit(1);

        // Owner 0: x out of range suppressed, corner pixel accepted.
        req = 4'b0001;
        wait_grant("range_grant", 4'b0001);
        send(0, 8'd160, 7'd5, 3'b011, 1'b0, 1'b0);
        chk("range_oob_plot", 32'(plot), 32'd0);
        chk("range_oob_cnt", 32'(pix_count), 32'd0);
        send(0, 8'd159, 7'd119, 3'b011, 1'b0, 1'b1);
        chk("range_ok_plot", 32'(plot), 32'd1);
        chk("range_ok_cnt", 32'(pix_count), 32'd1);
        release_unit(0);

        // Owner 2 stalls; watchdog revokes after TIMEOUT idle cycles.
        req = 4'b1100;
        wait_grant("wd_grant", 4'b0100);
        chk("wd_terr_pre", 32'(timeout_err), 32'd0);
        n = 1;
        do begin
            tick();
            if (grant == 4'b0100) n++;
        end while (grant == 4'b0100 && n < 2000);
        chk("wd_cycles", 32'(n), 32'd1024);
        chk("wd_terr", 32'(timeout_err), 32'd1);
        chk("wd_grant_drop", 32'(grant), 32'd0);
        req = 4'b1000;
        wait_grant("wd_next", 4'b1000);
        release_unit(3);

        // Pixel with done: plotted once; unit 3 traffic never forwarded.
        req = 4'b0001;
        wait_grant("pd_grant", 4'b0001);
        set_pix(3, 8'd77, 7'd55, 3'b001);
        pix_valid[3] = 1'b1;
        done[0] = 1'b1;
        req = '0;
        send(0, 8'd33, 7'd44, 3'b110, 1'b0, 1'b1);
        done = '0;
        chk("pd_plot", 32'({plot, x}), 32'({1'b1, 8'd33}));
        chk("pd_cnt", 32'(pix_count), 32'd1);
        for (int j = 0; j < 6; j++) begin
            pix_valid[3] = j[0];
            tick();
        end
        pix_valid = '0;
        chk("pd_idle_plot", 32'(plot), 32'd0);

        // Asynchronous reset mid-grant drops the in-flight pixel.
        req = 4'b0001;
        wait_grant("rst_mid_grant", 4'b0001);
        set_pix(0, 8'd1, 7'd1, 3'b111);
        pix_valid[0] = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_grant0", 32'(grant), 32'd0);
        chk("rst_mid_plot0", 32'(plot), 32'd0);
        chk("rst_mid_terr0", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;
        pix_valid = '0;
        req = 4'b1010;
        tick();
        chk("rst_rel_plot", 32'(plot), 32'd0);
        wait_grant("rst_rel_grant", 4'b0010);
        release_unit(1);
        repeat (4) tick();

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        chk("plot_total", 32'(n_plot), 32'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_time: got timeout expected finish");
        $fatal(1, "bench time limit");
    end
endmodule
